// File: rtl/mips_muldiv_unit_if.sv
// Bus between the CPU control/datapath and the multiply/divide unit.
//   master (CPU):  drives start, op, rs_content, rt_content; observes busy, done, hi, lo
//   slave  (unit): the reverse
interface mips_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_content;
  logic [WIDTH-1:0] rt_content;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_content, rt_content,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, rs_content, rt_content,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per
// cycle over WIDTH cycles, followed by one sign-fixup cycle.
// MTHI/MTLO write HI/LO directly from IDLE.
//   clk        : rising-edge clock
//   reset      : synchronous, active-low
//   clk_enable : 0 freezes all state
//   bus        : slave side of mips_muldiv_unit_if
//                (start/op/rs_content/rt_content in, busy/done/hi/lo out)
module mips_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  input logic               clk_enable,
  mips_muldiv_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;   // product / quotient sign
  logic               neg_rem;   // remainder sign (dividend sign)
  logic [WIDTH-1:0]   mcand;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc;       // product; low half doubles as dividend/quotient
  logic [WIDTH:0]     rem;

  logic               signed_op;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    signed_op = ~bus.op[0];
    rs_neg    = signed_op & bus.rs_content[WIDTH-1];
    rt_neg    = signed_op & bus.rt_content[WIDTH-1];
    rs_mag    = rs_neg ? -bus.rs_content : bus.rs_content;
    rt_mag    = rt_neg ? -bus.rt_content : bus.rt_content;

    mul_add   = acc[0] ? mcand : '0;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};

    div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    // rem[WIDTH] stays clear while rem < divisor; folding it in keeps the compare complete
    div_ge    = rem[WIDTH] | (div_shift >= {1'b0, mcand});
    div_diff  = div_shift - {1'b0, mcand};

    prod_fix  = neg_res ? -acc : acc;
    quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      rem      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else if (clk_enable) begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (!bus.op[2]) begin
              is_div  <= bus.op[1];
              mcand   <= bus.op[1] ? rt_mag : rs_mag;
              acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? rs_mag : rt_mag)};
              rem     <= '0;
              // Divide by zero yields all-ones quotient and |rs| remainder
              // naturally; suppressing the quotient sign leaves lo = all ones
              // and the remainder sign fix restores hi = rs_content.
              neg_res <= (rs_neg ^ rt_neg) & ~(bus.op[1] & (bus.rt_content == '0));
              neg_rem <= rs_neg;
              cnt     <= CW'(WIDTH - 1);
              bus.busy <= 1'b1;
              state   <= ITER;
            end else if (!bus.op[1]) begin
              if (bus.op[0]) bus.lo <= bus.rs_content;
              else           bus.hi <= bus.rs_content;
            end
          end
        end
        ITER: begin
          if (is_div) begin
            rem              <= div_ge ? div_diff : div_shift;
            acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          if (is_div) begin
            bus.hi <= rem_fix;
            bus.lo <= quo_fix;
          end else begin
            {bus.hi, bus.lo} <= prod_fix;
          end
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
module tb_mips_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst8;
  logic clk_en;
  logic en8;

  mips_muldiv_unit_if #(.WIDTH(32)) b32 ();
  mips_muldiv_unit_if #(.WIDTH(8))  b8 ();

  mips_muldiv_unit #(.WIDTH(32)) dut32 (
    .clk        (clk),
    .reset      (rst_n),
    .clk_enable (clk_en),
    .bus        (b32)
  );

  mips_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .reset      (rst8),
    .clk_enable (en8),
    .bus        (b8)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] e32_hi, e32_lo, e8_hi, e8_lo;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural HI/LO behaviour from plain integer arithmetic.
  function automatic void model(input int w, input logic [2:0] op,
                                input logic [63:0] a_in, input logic [63:0] b_in,
                                inout logic [63:0] hi, inout logic [63:0] lo);
    logic [63:0] mask, a, b, p;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    a  = a_in & mask;
    b  = b_in & mask;
    sa = a[w-1] ? ($signed(a) - (longint'(1) << w)) : $signed(a);
    sb = b[w-1] ? ($signed(b) - (longint'(1) << w)) : $signed(b);
    case (op)
      3'd0: begin p = sa * sb; hi = (p >> w) & mask; lo = p & mask; end
      3'd1: begin p = a * b;   hi = (p >> w) & mask; lo = p & mask; end
      3'd2: if (b == 0) begin hi = a; lo = mask; end
            else begin
              q = sa / sb; r = sa % sb;
              hi = $unsigned(r) & mask; lo = $unsigned(q) & mask;
            end
      3'd3: if (b == 0) begin hi = a; lo = mask; end
            else begin hi = a % b; lo = a / b; end
      3'd4: hi = a;
      3'd5: lo = a;
      default: ;
    endcase
  endfunction

  function automatic logic [63:0] rnd(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return mask;
      2: return 64'd1 << (w - 1);
      3: return 64'($urandom_range(0, 9));
      default: return 64'($urandom) & mask;
    endcase
  endfunction

  // Entered and left just after a negedge. Optionally injects an MTLO while
  // busy, stalls clk_enable, or aborts with reset after abort_at edges.
  task automatic op32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int stall, input bit inj, input int abort_at);
    int  edges;
    bit  seen;
    b32.start = 1'b1; b32.op = op; b32.rs_content = a; b32.rt_content = b;
    @(negedge clk);
    b32.start = 1'b0;
    check("busy_set", 64'(b32.busy), 64'd1);
    check("done_clear", 64'(b32.done), 64'd0);
    edges = 0;
    while (b32.done !== 1'b1 && edges < 300) begin
      b32.start      = inj && edges == 3;
      b32.op         = (inj && edges == 3) ? 3'd5 : op;
      b32.rs_content = (inj && edges == 3) ? 32'h55 : a;
      clk_en = !(edges >= 5 && edges < 5 + stall);
      rst_n  = !(abort_at >= 0 && edges == abort_at);
      if (edges == 5) begin
        check("hold_hi", 64'(b32.hi), e32_hi);
        check("hold_lo", 64'(b32.lo), e32_lo);
      end
      @(negedge clk);
      edges++;
      if (abort_at >= 0 && edges > abort_at) break;
    end
    b32.start = 1'b0; clk_en = 1'b1; rst_n = 1'b1;
    if (abort_at >= 0) begin
      e32_hi = 64'd0; e32_lo = 64'd0;
      check("abort_busy", 64'(b32.busy), 64'd0);
      check("abort_hi", 64'(b32.hi), e32_hi);
      check("abort_lo", 64'(b32.lo), e32_lo);
      seen = 1'b0;
      repeat (40) begin
        if (b32.done === 1'b1) seen = 1'b1;
        @(negedge clk);
      end
      check("abort_no_done", 64'(seen), 64'd0);
    end else begin
      model(32, op, 64'(a), 64'(b), e32_hi, e32_lo);
      check("latency", 64'(edges), 64'(33 + stall));
      check("hi", 64'(b32.hi), e32_hi);
      check("lo", 64'(b32.lo), e32_lo);
      check("busy_clear", 64'(b32.busy), 64'd0);
      if (stall > 0) begin
        clk_en = 1'b0;
        @(negedge clk);
        check("done_hold", 64'(b32.done), 64'd1);
        clk_en = 1'b1;
      end
    end
  endtask

  task automatic mt32(input logic [2:0] op, input logic [31:0] v);
    b32.start = 1'b1; b32.op = op; b32.rs_content = v;
    @(negedge clk);
    b32.start = 1'b0;
    model(32, op, 64'(v), 64'd0, e32_hi, e32_lo);
    check("mt_hi", 64'(b32.hi), e32_hi);
    check("mt_lo", 64'(b32.lo), e32_lo);
    check("mt_busy", 64'(b32.busy), 64'd0);
    check("mt_done", 64'(b32.done), 64'd0);
  endtask

  task automatic op8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int edges;
    b8.start = 1'b1; b8.op = op; b8.rs_content = a; b8.rt_content = b;
    @(negedge clk);
    b8.start = 1'b0;
    edges = 0;
    while (b8.done !== 1'b1 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    model(8, op, 64'(a), 64'(b), e8_hi, e8_lo);
    check("w8_latency", 64'(edges), 64'd9);
    check("w8_hi", 64'(b8.hi), e8_hi);
    check("w8_lo", 64'(b8.lo), e8_lo);
    @(negedge clk);
    check("w8_done_pulse", 64'(b8.done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; rst8 = 1'b0; clk_en = 1'b1; en8 = 1'b1;
    b32.start = 1'b0; b32.op = 3'd0; b32.rs_content = '0; b32.rt_content = '0;
    b8.start  = 1'b0; b8.op  = 3'd0; b8.rs_content  = '0; b8.rt_content  = '0;
    e32_hi = 64'd0; e32_lo = 64'd0; e8_hi = 64'd0; e8_lo = 64'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; rst8 = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(b32.busy), 64'd0);
    check("rst_done", 64'(b32.done), 64'd0);
    check("rst_hi", 64'(b32.hi), 64'd0);
    check("rst_lo", 64'(b32.lo), 64'd0);
    check("rst8_hi", 64'(b8.hi), 64'd0);
    check("rst8_lo", 64'(b8.lo), 64'd0);

    op32(3'd0, 32'hFFFF_FFFD, 32'd7, 0, 1'b0, -1);
    op32(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, -1);
    op32(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, -1);
    op32(3'd3, 32'd100, 32'd0, 0, 1'b0, -1);
    op32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, -1);
    op32(3'd2, 32'hFFFF_FF9C, 32'd0, 0, 1'b0, -1);
    mt32(3'd4, 32'h1234_5678);
    mt32(3'd5, 32'h9ABC_DEF0);
    mt32(3'd6, 32'h1111_1111);
    mt32(3'd7, 32'h2222_2222);
    op32(3'd3, 32'd1000, 32'd7, 0, 1'b1, -1);
    op32(3'd3, 32'hDEAD_BEEF, 32'h1234, 5, 1'b0, -1);
    op32(3'd3, 32'hDEAD_BEEF, 32'h99, 0, 1'b0, 10);

    // reset and start on the same edge: reset wins
    b32.start = 1'b1; b32.op = 3'd0; b32.rs_content = 32'd5; b32.rt_content = 32'd3;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; b32.start = 1'b0;
    check("rst_win_busy", 64'(b32.busy), 64'd0);
    @(negedge clk);
    check("rst_win_busy2", 64'(b32.busy), 64'd0);
    check("rst_win_lo", 64'(b32.lo), 64'd0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0)
        mt32(3'($urandom_range(4, 7)), 32'(rnd(32)));
      op32(3'($urandom_range(0, 3)), 32'(rnd(32)), 32'(rnd(32)), 0, 1'b0, -1);
    end
    mt32(3'd6, 32'd0);

    op8(3'd0, 8'h80, 8'h80);
    op8(3'd3, 8'hFF, 8'h10);
    for (int i = 0; i < 20; i++)
      op8(3'($urandom_range(0, 3)), 8'(rnd(8)), 8'(rnd(8)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
